// File: rtl/ws2812_encoder.sv
// WS2812 single-wire transmitter: serialises GRB (or GRBW with WS2812_RGBW_EN) pixel words
// into the NRZ high/low pulse train, MSB first, timed by a shared clock-enable tick.
// A one-entry holding register lets the next pixel stream in with no gap between pixels.
// Optional feature macro: WS2812_RGBW_EN (32-bit GRBW pixels instead of 24-bit GRB).
`timescale 1ns/1ps

module ws2812_encoder #(
    parameter int unsigned T0H         = 8,
    parameter int unsigned T0L         = 17,
    parameter int unsigned T1H         = 16,
    parameter int unsigned T1L         = 9,
    parameter int unsigned RESET_TICKS = 1200
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_count_enable,
    input  logic        i_pixel_valid,
    input  logic [31:0] i_pixel_data,
    input  logic        i_pixel_last,
    output logic        o_pixel_ready,
    output logic        o_dout,
    output logic        o_busy,
    output logic        o_underrun
);

`ifdef WS2812_RGBW_EN
    localparam int unsigned NBITS = 32;
`else
    localparam int unsigned NBITS = 24;
`endif

    localparam int unsigned MaxA = (T0H > T0L) ? T0H : T0L;
    localparam int unsigned MaxB = (T1H > T1L) ? T1H : T1L;
    localparam int unsigned MaxC = (MaxA > MaxB) ? MaxA : MaxB;
    localparam int unsigned MaxT = (MaxC > RESET_TICKS) ? MaxC : RESET_TICKS;
    localparam int unsigned CntW = $clog2(MaxT) + 1;
    localparam int unsigned IdxW = $clog2(NBITS);

    typedef enum logic [1:0] {StIdle, StHigh, StLow, StLatch} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [IdxW-1:0]    idx_q, idx_d;
    logic [NBITS-1:0]   shift_q, shift_d;
    logic               last_q, last_d;
    logic [NBITS-1:0]   hold_q, hold_d;
    logic               hold_last_q, hold_last_d;
    logic               hold_full_q, hold_full_d;
    logic               dout_q, dout_d;
    logic               underrun_q, underrun_d;

    logic [NBITS-1:0]   pixel_in;
    logic               launch;
    logic               cur_bit;
    logic [CntW-1:0]    high_end;
    logic [CntW-1:0]    low_end;

    // Only the transmitted top bits of the pixel word are stored.
    assign pixel_in = i_pixel_data[31 -: NBITS];
`ifndef WS2812_RGBW_EN
    logic unused_w;
    assign unused_w = ^i_pixel_data[7:0];
`endif

    assign cur_bit  = shift_q[NBITS-1];
    assign high_end = cur_bit ? CntW'(T1H - 1) : CntW'(T0H - 1);
    assign low_end  = cur_bit ? CntW'(T1L - 1) : CntW'(T0L - 1);

    assign o_pixel_ready = !hold_full_q;
    assign o_dout        = dout_q;
    assign o_busy        = !((state_q == StIdle) && !hold_full_q);
    assign o_underrun    = underrun_q;

    // Next-state logic: holding-register accept, bit timing FSM and pixel launch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        last_d      = last_q;
        hold_d      = hold_q;
        hold_last_d = hold_last_q;
        hold_full_d = hold_full_q;
        underrun_d  = 1'b0;
        launch      = 1'b0;

        // Accept only into an empty hold, so accept and launch never hit the same entry.
        if (i_pixel_valid && !hold_full_q) begin
            hold_d      = pixel_in;
            hold_last_d = i_pixel_last;
            hold_full_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (hold_full_q) begin
                    launch = 1'b1;
                end
            end
            StHigh: begin
                if (i_count_enable) begin
                    if (cnt_q == high_end) begin
                        state_d = StLow;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StLow: begin
                if (i_count_enable) begin
                    if (cnt_q == low_end) begin
                        cnt_d = '0;
                        if (idx_q != '0) begin
                            shift_d = shift_q << 1;
                            idx_d   = idx_q - 1'b1;
                            state_d = StHigh;
                        end else if (last_q) begin
                            state_d = StLatch;
                        end else if (hold_full_q) begin
                            launch = 1'b1;
                        end else begin
                            state_d    = StIdle;
                            underrun_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StLatch: begin
                if (i_count_enable) begin
                    if (cnt_q == CntW'(RESET_TICKS - 1)) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        // Launch moves the held pixel into the shifter and starts its MSB high phase.
        if (launch) begin
            shift_d     = hold_q;
            last_d      = hold_last_q;
            idx_d       = IdxW'(NBITS - 1);
            hold_full_d = 1'b0;
            state_d     = StHigh;
            cnt_d       = '0;
        end
    end

    assign dout_d = (state_d == StHigh);

    // State and datapath registers; reset drops the line low at once.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            last_q      <= 1'b0;
            hold_q      <= '0;
            hold_last_q <= 1'b0;
            hold_full_q <= 1'b0;
            dout_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            last_q      <= last_d;
            hold_q      <= hold_d;
            hold_last_q <= hold_last_d;
            hold_full_q <= hold_full_d;
            dout_q      <= dout_d;
            underrun_q  <= underrun_d;
        end
    end

endmodule
